// File: rtl/fifo_stream_reader_if.sv
// rtl/fifo_stream_reader_if.sv - FIFO pop port and output stream bundle for fifo_stream_reader
interface fifo_stream_reader_if #(
  parameter int WORD_LENGTH = 8
);
  logic                   fifo_rd_en;
  logic                   fifo_empty;
  logic [WORD_LENGTH-1:0] fifo_data;
  logic                   m_valid;
  logic                   m_ready;
  logic [WORD_LENGTH-1:0] m_data;

  modport master (
    output fifo_rd_en,
    input  fifo_empty,
    input  fifo_data,
    output m_valid,
    input  m_ready,
    output m_data
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_empty,
    output fifo_data,
    input  m_valid,
    output m_ready,
    input  m_data
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - drains a one-cycle-latency FIFO pop port into a valid/ready stream
module fifo_stream_reader #(
  parameter int WORD_LENGTH = 8,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  fifo_stream_reader_if.master io_bus,
  input  logic                 i_flush,
  output logic [CNT_WIDTH-1:0] o_words_sent,
  output logic                 o_idle
);

  logic [WORD_LENGTH-1:0] r_head;
  logic [WORD_LENGTH-1:0] r_tail;
  logic [1:0]             r_occ;
  logic                   r_inflight;
  logic [CNT_WIDTH-1:0]   r_words_sent;

  logic       w_hs;
  logic       w_rd_en;
  logic [2:0] w_committed;

  assign io_bus.m_valid = (r_occ != 2'd0) && !i_flush;
  assign io_bus.m_data  = r_head;
  assign w_hs           = io_bus.m_valid && io_bus.m_ready;

  // Slots already owed to buffered or in-flight words, net of the word leaving this cycle
  assign w_committed = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_hs};
  assign w_rd_en     = !io_bus.fifo_empty && !i_flush && !reset && (w_committed < 3'd2);

  assign io_bus.fifo_rd_en = w_rd_en;
  assign o_words_sent      = r_words_sent;
  assign o_idle            = (r_occ == 2'd0) && !r_inflight && io_bus.fifo_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_occ        <= 2'd0;
      r_inflight   <= 1'b0;
      r_words_sent <= '0;
    end else if (i_flush) begin
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_rd_en;
      if (w_hs) begin
        r_words_sent <= r_words_sent + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
      // Arriving word always lands behind whatever survives this cycle's handshake
      case ({r_inflight, w_hs})
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_head <= io_bus.fifo_data;
          end else begin
            r_head <= r_tail;
            r_tail <= io_bus.fifo_data;
          end
        end
        2'b01: begin
          r_head <= r_tail;
          r_occ  <= r_occ - 2'd1;
        end
        2'b10: begin
          if (r_occ == 2'd0) begin
            r_head <= io_bus.fifo_data;
          end else begin
            r_tail <= io_bus.fifo_data;
          end
          r_occ <= r_occ + 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side adapter for the team's internal synchronous FIFO. It drains words from the FIFO's raw pop port (read_en / empty / data_out, one-cycle read latency) and presents them as a valid/ready stream to a downstream consumer. Two words are held in a local buffer so a word is delivered every cycle under continuous m_ready. The block sits between the FIFO output and any stream sink such as a serializer or bus master.

## Interface
- WORD_LENGTH, 8: data width, equal to the FIFO word width.
- CNT_WIDTH, 16: width of the delivered-word counter.

- clk  in  1  clock, all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- fifo_rd_en  out  1  pop request to the FIFO (its read_en).
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  WORD_LENGTH  FIFO read data, valid the cycle after an accepted pop.
- flush  in  1  synchronous discard of all buffered and in-flight words.
- m_valid  out  1  stream word valid.
- m_ready  in  1  sink ready.
- m_data  out  WORD_LENGTH  stream word.
- words_sent  out  CNT_WIDTH  count of completed handshakes, wraps modulo 2^CNT_WIDTH.
- idle  out  1  high when occ == 0, no pop is in flight, and fifo_empty is high.

## Operation
- State consists of a 2-entry in-order buffer (head/tail registers), occupancy occ in {0,1,2}, and an inflight flag (pop issued last cycle).
- pop = fifo_rd_en && !fifo_empty. A pop sets inflight for the next cycle. On that next cycle, fifo_data is written to the buffer tail.
- handshake = m_valid && m_ready. It removes the head word; the second entry becomes the head.
- fifo_rd_en = !fifo_empty && !flush && !reset && (occ + inflight - handshake) < 2. This is combinational from m_ready; it never overcommits the 2-entry buffer.
- m_valid = (occ != 0) && !flush. m_data is the head register, never combinational from fifo_data.
- When a word arrives and a handshake occur in the same cycle, occ is unchanged and the order is preserved.
- Words are delivered in exact FIFO order. None are dropped or duplicated, except on flush or reset.
- flush has priority over every other event in its cycle:
  - occ <= 0 and inflight <= 0.
  - A word arriving in the flush cycle is discarded.
  - No handshake is counted.
  - fifo_rd_en is low, so nothing arrives after the flush cycle.
- words_sent increments by 1 per handshake and wraps from all-ones to 0. flush does not clear it.

## Timing
- Reset values: occ=0, inflight=0, m_valid=0, m_data=0, words_sent=0, fifo_rd_en=0 during the reset cycle, idle follows fifo_empty.
- Reset mid-operation drops buffered words and any in-flight word. The word returned by the FIFO in the cycle after reset is ignored.
- Latency from the first pop in cycle t to m_valid: m_valid is high in cycle t+2, with data captured at the end of t+1.
- Throughput: 1 word/cycle with m_ready held high and the FIFO non-empty.
- Backpressure: with m_ready low, at most 2 pops are issued, then fifo_rd_en stays low. When m_ready rises, fifo_rd_en may assert in the same cycle.
- m_valid, once high, stays high with stable m_data until a handshake occurs, except on flush or reset.

## Test plan
- Reset: assert reset for 2 cycles with a FIFO holding data. Required: m_valid=0, fifo_rd_en=0, words_sent=0 throughout, and idle=0 because the FIFO is non-empty.
- Streaming: preload 0x11, 0x22, 0x33 with m_ready=1. Required: fifo_rd_en high in cycles 0–2; m_data 0x11/0x22/0x33 in cycles 2/3/4; words_sent=3; idle=1 from cycle 5.
- Backpressure: preload 0xA0..0xA4 with m_ready=0 for 6 cycles. Required: exactly 2 pops, occ=2, m_data=0xA0 stable. Then set m_ready=1. Required: 0xA0..0xA4 appear in order on consecutive cycles.
- Flush: with occ=2 and one pop in flight, pulse flush. Required: m_valid=0 the next cycle, the in-flight word is discarded, and the next delivered word is the FIFO's next unread word.
- Counter wrap: set CNT_WIDTH=4 and stream 17 words. Required: words_sent reads 15 after word 15, 0 after word 16, and 1 after word 17.
- Reset mid-stream: assert reset while occ=1 and inflight=1. Required: m_valid=0 the cycle after, with no stale word ever emitted.
